// File: rtl/num_sort_pkg.sv
`default_nettype none
// ============================================================================
// Module      : num_sort_pkg
// Description : Shared widths, frame size and FSM states for num_sort_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package num_sort_pkg;

    localparam int N_CLASS = 10;
    localparam int DATA_W  = 16;
    localparam int IDX_W   = 4;
    localparam int FRAME_W = N_CLASS * DATA_W;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LOAD    = 2'd1,
        WAIT    = 2'd2,
        RESULT  = 2'd3
    } state_e;

    // One counter width covers both the beat count and the WAIT timeout.
    function automatic int cnt_width(input int n_class, input int timeout);
        int m;
        m = (n_class > timeout + 1) ? n_class : timeout + 1;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sort_frame_packer.sv
`default_nettype none
// ============================================================================
// Module      : sort_frame_packer
// Description : Beat counter, MS-first slot writes and short-frame detection.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_frame_packer
    import num_sort_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               beat_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic               last_i,
    output logic [FRAME_W-1:0] frame_o,
    output logic [CNT_W-1:0]   cnt_o,
    output logic               frame_done_o,
    output logic               len_err_o
);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_CLASS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The 10th beat closes the frame even if in_last is low on it.
    always_comb begin
        cnt_d        = cnt_q;
        frame_done_o = 1'b0;
        len_err_o    = 1'b0;
        if (beat_i) begin
            if (cnt_q == LAST_SLOT) begin
                cnt_d        = '0;
                frame_done_o = 1'b1;
            end else if (last_i) begin
                cnt_d     = '0;
                len_err_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar k = 0; k < N_CLASS; k++) begin : g_slot
        logic [DATA_W-1:0] slot_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                slot_q <= '0;
            end else if (beat_i && (cnt_q == CNT_W'(k))) begin
                slot_q <= data_i;
            end
        end

        assign frame_o[(N_CLASS-1-k)*DATA_W +: DATA_W] = slot_q;
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/num_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : num_sort_ctrl
// Description : Collects a score frame, drives num_sort and returns its result.
// Revision    : 1.0 - initial release
// ============================================================================
module num_sort_ctrl
    import num_sort_pkg::*;
#(
    parameter int LOAD_CYCLES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic [FRAME_W-1:0] sort_data,
    output logic               sort_load,
    input  logic               sort_complete,
    input  logic [IDX_W-1:0]   sort_index,
    input  logic [FRAME_W-1:0] sort_data_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDX_W-1:0]   res_index,
    output logic [FRAME_W-1:0] res_data,
    output logic               busy,
    output logic               err_len,
    output logic               err_timeout
);

    localparam int               CNT_W     = cnt_width(N_CLASS, TIMEOUT);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   beat_cnt;
    logic               complete_q;
    logic [IDX_W-1:0]   res_index_q;
    logic [FRAME_W-1:0] res_data_q;
    logic               err_len_q, err_timeout_q, timeout_d;
    logic               beat, frame_done, len_err, capture;

    assign in_ready = (state_q == COLLECT);
    assign beat     = in_valid & in_ready;
    // Only a fresh edge counts: a complete already high on WAIT entry is stale.
    assign capture  = (state_q == WAIT) & sort_complete & ~complete_q;

    sort_frame_packer #(
        .CNT_W(CNT_W)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .beat_i      (beat),
        .data_i      (in_data),
        .last_i      (in_last),
        .frame_o     (sort_data),
        .cnt_o       (beat_cnt),
        .frame_done_o(frame_done),
        .len_err_o   (len_err)
    );

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        timeout_d = 1'b0;
        case (state_q)
            COLLECT: begin
                if (frame_done) begin
                    state_d = LOAD;
                    cyc_d   = '0;
                end
            end
            LOAD: begin
                if (cyc_q == LOAD_LAST) begin
                    state_d = WAIT;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            WAIT: begin
                // Capture takes priority over a timeout in the same cycle.
                if (capture) begin
                    state_d = RESULT;
                end else if (cyc_q == TMO_LAST) begin
                    state_d   = COLLECT;
                    timeout_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= COLLECT;
            cyc_q         <= '0;
            complete_q    <= 1'b0;
            res_index_q   <= '0;
            res_data_q    <= '0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            complete_q    <= sort_complete;
            err_len_q     <= len_err;
            err_timeout_q <= timeout_d;
            if (capture) begin
                res_index_q <= sort_index;
                res_data_q  <= sort_data_out;
            end
        end
    end

    assign sort_load   = (state_q == LOAD);
    assign res_valid   = (state_q == RESULT);
    assign res_index   = res_index_q;
    assign res_data    = res_data_q;
    assign busy        = (state_q != COLLECT) || (beat_cnt != '0);
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_num_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_num_sort_ctrl
// Description : Self-checking bench for num_sort_ctrl with a num_sort model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_num_sort_ctrl;
    import num_sort_pkg::*;

    localparam int LOAD_CYCLES = 2;
    localparam int TIMEOUT     = 255;

    typedef logic signed [DATA_W-1:0] score_t;
    typedef score_t frame_t [N_CLASS];
    typedef struct {
        frame_t             beats;
        logic               last_on_final;
        int                 delay;
        int                 bp;
        logic [FRAME_W-1:0] exp_frame;
        logic [IDX_W-1:0]   exp_idx;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst, in_valid, in_last, in_ready, sort_load, sort_complete;
    logic [DATA_W-1:0]  in_data;
    logic [FRAME_W-1:0] sort_data, sort_data_out, res_data;
    logic [IDX_W-1:0]   sort_index, res_index;
    logic               res_valid, res_ready, busy, err_len, err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    num_sort_ctrl #(.LOAD_CYCLES(LOAD_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .sort_data(sort_data), .sort_load(sort_load),
        .sort_complete(sort_complete), .sort_index(sort_index), .sort_data_out(sort_data_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
        .res_data(res_data), .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
    );

    task automatic check(input string name, input logic [FRAME_W-1:0] act,
                         input logic [FRAME_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First beat shifted in first ends up in the most-significant slot.
    function automatic logic [FRAME_W-1:0] model_pack(input frame_t f);
        logic [FRAME_W-1:0] v;
        v = '0;
        for (int k = 0; k < N_CLASS; k++) v = {v[FRAME_W-DATA_W-1:0], f[k]};
        return v;
    endfunction

    // num_sort model: arg-max (first occurrence) and descending sorted vector.
    task automatic model_sort(input frame_t f, output logic [IDX_W-1:0] idx,
                              output logic [FRAME_W-1:0] dout);
        frame_t s;
        int     best;
        score_t t;
        s    = f;
        best = 0;
        for (int k = 1; k < N_CLASS; k++) if (f[k] > f[best]) best = k;
        for (int i = 0; i < N_CLASS; i++)
            for (int j = 0; j < N_CLASS - 1 - i; j++)
                if (s[j] < s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        idx  = IDX_W'(best);
        dout = model_pack(s);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},    in_ready,    1);
        check({tag, "_sort_load"},   sort_load,   0);
        check({tag, "_sort_data"},   sort_data,   0);
        check({tag, "_res_valid"},   res_valid,   0);
        check({tag, "_res_index"},   res_index,   0);
        check({tag, "_res_data"},    res_data,    0);
        check({tag, "_busy"},        busy,        0);
        check({tag, "_err_len"},     err_len,     0);
        check({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    // last_at < 0 means no in_last on any beat.
    task automatic send_frame(input frame_t f, input int n, input int last_at, input int gap_max);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                in_last  = 1'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = f[k];
            in_last  = (k == last_at);
            check("in_ready_collect", in_ready, 1);
            tick();
            if (k == 0 && n > 1) check("busy_mid_frame", busy, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_load(input logic [FRAME_W-1:0] exp_frame);
        check("err_len_full", err_len, 0);
        for (int i = 0; i < LOAD_CYCLES; i++) begin
            check("sort_load_hi", sort_load, 1);
            check("sort_data", sort_data, exp_frame);
            check("in_ready_load", in_ready, 0);
            tick();
        end
        check("sort_load_lo", sort_load, 0);
        check("sort_data_wait", sort_data, exp_frame);
    endtask

    task automatic finish_result(input int delay, input int bp, input logic [IDX_W-1:0] drv_idx,
                                 input logic [FRAME_W-1:0] drv_dout,
                                 input logic [IDX_W-1:0] exp_idx);
        for (int i = 0; i < delay; i++) begin
            check("res_valid_wait", res_valid, 0);
            tick();
        end
        sort_complete = 1'b1;
        sort_index    = drv_idx;
        sort_data_out = drv_dout;
        check("res_valid_pre", res_valid, 0);
        tick();
        check("res_valid", res_valid, 1);
        check("res_index", res_index, exp_idx);
        check("res_data", res_data, drv_dout);
        sort_complete = 1'b0;
        sort_index    = 4'($urandom);
        sort_data_out = {5{$urandom}};
        for (int i = 0; i < bp; i++) begin
            tick();
            check("bp_res_valid", res_valid, 1);
            check("bp_res_index", res_index, exp_idx);
            check("bp_res_data", res_data, drv_dout);
            check("bp_in_ready", in_ready, 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_valid_drop", res_valid, 0);
        check("in_ready_after", in_ready, 1);
    endtask

    task automatic run_frame(input frame_t f, input logic last_on_final, input int gap_max,
                             input int delay, input int bp, input logic [FRAME_W-1:0] exp_frame,
                             input logic [IDX_W-1:0] exp_idx);
        logic [IDX_W-1:0]   idx;
        logic [FRAME_W-1:0] dout;
        send_frame(f, N_CLASS, last_on_final ? N_CLASS - 1 : -1, gap_max);
        check_load(exp_frame);
        model_sort(f, idx, dout);
        finish_result(delay, bp, idx, dout, exp_idx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t               tbl [3];
        frame_t             f;
        logic [IDX_W-1:0]   idx;
        logic [FRAME_W-1:0] dout;
        logic               bad;

        tbl[0].beats = '{16'sd6, 16'sd8, 16'sd7, 16'sd0, 16'sd5, 16'sd9, 16'sd3, 16'sd2, 16'sd1, 16'sd4};
        tbl[0].last_on_final = 1'b1; tbl[0].delay = 12; tbl[0].bp = 0;
        tbl[0].exp_frame = 160'h0006_0008_0007_0000_0005_0009_0003_0002_0001_0004;
        tbl[0].exp_idx   = 4'd5;
        tbl[1].beats = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h0002,
                         16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007};
        tbl[1].last_on_final = 1'b0; tbl[1].delay = 3; tbl[1].bp = 5;
        tbl[1].exp_frame = 160'hFFFF_7FFF_8000_0001_0002_0003_0004_0005_0006_0007;
        tbl[1].exp_idx   = 4'd1;
        tbl[2].beats = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                         16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFE};
        tbl[2].last_on_final = 1'b1; tbl[2].delay = 0; tbl[2].bp = 1;
        tbl[2].exp_frame = 160'h8000_8000_8000_8000_8000_8000_8000_8000_8000_FFFE;
        tbl[2].exp_idx   = 4'd9;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        sort_complete = 1'b0; sort_index = '0; sort_data_out = '0; res_ready = 1'b0;
        tick();
        check_reset_vals("reset");
        tick();
        rst = 1'b0;

        // Short frame: in_last on the 3rd beat.
        f = tbl[0].beats;
        send_frame(f, 3, 2, 0);
        check("short_err_len", err_len, 1);
        check("short_in_ready", in_ready, 1);
        check("short_busy", busy, 0);
        tick();
        check("short_err_len_drop", err_len, 0);

        foreach (tbl[i])
            run_frame(tbl[i].beats, tbl[i].last_on_final, 0, tbl[i].delay, tbl[i].bp,
                      tbl[i].exp_frame, tbl[i].exp_idx);

        // Stale complete held high from a previous run through LOAD.
        foreach (f[k]) f[k] = 16'($urandom);
        sort_complete = 1'b1;
        sort_index    = 4'd15;
        sort_data_out = {5{32'hDEAD_BEEF}};
        send_frame(f, N_CLASS, N_CLASS - 1, 0);
        check_load(model_pack(f));
        repeat (4) begin
            tick();
            check("stale_no_capture", res_valid, 0);
        end
        sort_complete = 1'b0;
        tick();
        check("stale_drop_no_capture", res_valid, 0);
        model_sort(f, idx, dout);
        finish_result(0, 0, idx, dout, idx);

        // Timeout: complete never arrives.
        foreach (f[k]) f[k] = 16'($urandom);
        send_frame(f, N_CLASS, N_CLASS - 1, 0);
        check_load(model_pack(f));
        bad = 1'b0;
        for (int j = 0; j < TIMEOUT; j++) begin
            if (err_timeout !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0) bad = 1'b1;
            tick();
        end
        check("timeout_wait_window", bad, 0);
        check("timeout_pulse", err_timeout, 1);
        check("timeout_in_ready", in_ready, 1);
        check("timeout_busy", busy, 0);
        check("timeout_res_valid", res_valid, 0);
        tick();
        check("timeout_pulse_drop", err_timeout, 0);

        // Reset in the middle of WAIT, then a late complete pulse.
        foreach (f[k]) f[k] = 16'($urandom);
        send_frame(f, N_CLASS, N_CLASS - 1, 0);
        check_load(model_pack(f));
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("midwait_rst");
        repeat (2) tick();
        sort_complete = 1'b1;
        sort_index    = 4'd7;
        tick();
        sort_complete = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            if (res_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
            tick();
        end
        check("late_complete_ignored", bad, 0);

        // Randomised frames with bubbles, response delays and backpressure.
        for (int r = 0; r < 25; r++) begin
            foreach (f[k]) f[k] = 16'($urandom);
            model_sort(f, idx, dout);
            run_frame(f, 1'($urandom), 2, $urandom_range(0, 15), $urandom_range(0, 4),
                      model_pack(f), idx);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/num_sort_ctrl.md
Name: num_sort_ctrl

Overview:
Sequencer for the num_sort unit, the 10-entry signed 16-bit sorter/arg-selector at the classifier output.
- Collects one score per beat from the upstream layer over a valid/ready stream and packs the frame into the 160-bit sorter input.
- Drives the sorter load pulse, waits for its completion and captures index and sorted data.
- Presents the captured result downstream under a valid/ready handshake, with length and timeout error reporting.

Parameters:
N_CLASS, 10, scores per frame.
DATA_W, 16, signed score width.
IDX_W, 4, index width; must be at least clog2(N_CLASS).
LOAD_CYCLES, 2, number of cycles sort_load is held high.
TIMEOUT, 255, maximum cycles in WAIT before aborting.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  upstream score valid.
in_data  in  DATA_W  signed score.
in_last  in  1  marks the final beat of a frame.
in_ready  out  1  controller accepts a score.
sort_data  out  N_CLASS*DATA_W  packed frame to num_sort.data.
sort_load  out  1  to num_sort.load.
sort_complete  in  1  from num_sort.complete.
sort_index  in  IDX_W  from num_sort.index.
sort_data_out  in  N_CLASS*DATA_W  from num_sort.data_out.
res_valid  out  1  result available.
res_ready  in  1  downstream accepts result.
res_index  out  IDX_W  captured index.
res_data  out  N_CLASS*DATA_W  captured sorted vector.
busy  out  1  high when state is not COLLECT or the beat count is non-zero.
err_len  out  1  one-cycle pulse: short frame.
err_timeout  out  1  one-cycle pulse: sorter did not complete.

Behaviour:
- Reset: synchronous, active-high. The clock is clk and the reset is rst; one clock; polarity and synchronicity are fixed.
- On rst=1 at a clock edge, the next cycle is: state COLLECT, cnt=0, in_ready=1, sort_load=0, sort_data=0, res_valid=0, res_index=0, res_data=0, busy=0, err_len=0, err_timeout=0, complete_q=0.
- Rst is honoured in any state; a late sort_complete after reset is ignored until a new frame has been loaded.
- Packing: the k-th accepted beat (k=0..N_CLASS-1) is written to sort_data[(N_CLASS-1-k)*DATA_W +: DATA_W]. The first score therefore lands in the MS slot.
- FSM states: COLLECT, LOAD, WAIT, RESULT.
- COLLECT:
  - in_ready=1; a beat is accepted when in_valid & in_ready.
  - If in_last=1 on an accepted beat with cnt<N_CLASS-1: err_len pulses the next cycle, cnt returns to 0, the partial frame is discarded and the state stays COLLECT.
  - If the beat with cnt==N_CLASS-1 is accepted: go to LOAD, whatever the value of in_last.
- LOAD:
  - sort_load=1 for exactly LOAD_CYCLES cycles, starting the cycle after the 10th beat is accepted; then go to WAIT.
  - sort_data is held stable from LOAD through the end of WAIT.
- WAIT:
  - sort_load=0; a timeout counter increments each cycle.
  - complete_q registers sort_complete every cycle in all states.
  - Capture happens only on a rising edge detected in WAIT (sort_complete & ~complete_q). A complete that is high on WAIT entry is stale and is ignored.
  - On capture: res_index<=sort_index and res_data<=sort_data_out; go to RESULT.
  - If the counter reaches TIMEOUT without a capture: err_timeout pulses for one cycle and the state returns to COLLECT with cnt=0.
  - If capture and timeout occur in the same cycle, capture wins.
- RESULT:
  - res_valid=1; res_index and res_data are held stable.
  - On res_valid & res_ready, go to COLLECT the next cycle with res_valid=0.
- in_ready=0 in LOAD, WAIT and RESULT; there is no frame overlap.
- Latency: from the last beat accepted (edge t), sort_load is high at t+1..t+LOAD_CYCLES. res_valid rises the cycle after the complete rising edge is sampled.
- Widths: scores pass through untouched. The controller performs no arithmetic on data; counters are sized to clog2(max(N_CLASS, TIMEOUT+1)).

Decomposition:
- Package num_sort_pkg holds: N_CLASS, DATA_W, IDX_W, the FRAME_W=N_CLASS*DATA_W constant, and the state enum {COLLECT, LOAD, WAIT, RESULT}.
- One sub-module: sort_frame_packer, containing the beat counter, slot write into the frame register, and short-frame detection. It outputs frame_done and len_err.
- The FSM, timeout counter and result register stay in num_sort_ctrl.

Test Plan:
- Nominal frame: beats 6,8,7,0,5,9,3,2,1,4 back-to-back.
  - sort_data=160'h0006_0008_0007_0000_0005_0009_0003_0002_0001_0004, and sort_load is high exactly 2 cycles.
  - The model raises complete 12 cycles later with index=4'd5, then res_valid=1 and res_index=5 the following cycle.
- Short frame: in_last on the 3rd beat -> err_len one-cycle pulse, in_ready stays 1. The next full 10-beat frame is packed from slot MS and processed normally.
- Timeout: the model never raises complete, TIMEOUT=255 -> err_timeout pulses on the 255th WAIT cycle; the state is COLLECT with in_ready=1, and res_valid is never asserted.
- Stale complete: the model holds complete=1 from the previous run through LOAD.
  - No capture occurs until complete drops and rises again.
  - res_data equals the model's new data_out.
- Backpressure: res_ready=0 for 5 cycles -> res_valid, res_index and res_data are constant and in_ready=0; res_ready=1 -> in_ready=1 the next cycle.
- Reset mid-WAIT: rst=1 for one cycle -> all outputs are at reset values the next cycle. A complete pulse 3 cycles later produces no res_valid.
